// File: rtl/control_juego.sv
// Pong match sequencer: match FSM, scores and frame-tick gated paddle pulses.
// Define CONTROL_JUEGO_AI_P2_EN to have player 2 track the ball automatically.
module control_juego #(
    parameter int unsigned WIN_SCORE    = 9,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 90,
    parameter int unsigned AI_DEADBAND  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    input  logic       miss_left,
    input  logic       miss_right,
    input  logic [9:0] ball_y,
    input  logic [9:0] p2_y,
    output logic       p1_up_o,
    output logic       p1_down_o,
    output logic       p2_up_o,
    output logic       p2_down_o,
    output logic       paddle_center,
    output logic       ball_run,
    output logic       serve_dir,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StServe    = 3'd1,
        StPlay     = 3'd2,
        StPoint    = 3'd3,
        StGameOver = 3'd4
    } state_e;

    localparam logic [3:0] WinScore    = 4'(WIN_SCORE);
    localparam logic [7:0] ServeFrames = 8'(SERVE_FRAMES);
    localparam logic [7:0] PointFrames = 8'(POINT_FRAMES);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] score1_q, score1_d, score2_q, score2_d;
    logic [1:0] winner_q, winner_d;
    logic       serve_dir_q, serve_dir_d;
    logic       center_q, center_d;
    logic       ball_run_q, ball_run_d;
    logic       start_q;
    logic       p1_up_q, p1_down_q, p2_up_q, p2_down_q;
    logic       p1_up_d, p1_down_d, p2_up_d, p2_down_d;
    logic       start_edge, move_en;
    logic       p2_up_req, p2_down_req;

    assign start_edge = start & ~start_q;
    assign move_en    = (state_q == StServe) || (state_q == StPlay);

`ifdef CONTROL_JUEGO_AI_P2_EN
    logic [10:0] ball_y_w, p2_y_w;
    logic        unused_p2_buttons;

    assign ball_y_w          = {1'b0, ball_y};
    assign p2_y_w            = {1'b0, p2_y};
    assign p2_up_req         = ball_y_w > (p2_y_w + 11'(AI_DEADBAND));
    assign p2_down_req       = (ball_y_w + 11'(AI_DEADBAND)) < p2_y_w;
    assign unused_p2_buttons = p2_up ^ p2_down;
`else
    logic unused_ai;

    assign p2_up_req   = p2_up;
    assign p2_down_req = p2_down;
    assign unused_ai   = ^{ball_y, p2_y, 10'(AI_DEADBAND)};
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        winner_d    = winner_q;
        serve_dir_d = serve_dir_q;
        center_d    = 1'b0;

        case (state_q)
            StIdle, StGameOver: begin
                if (start_edge) begin
                    state_d     = StServe;
                    score1_d    = 4'd0;
                    score2_d    = 4'd0;
                    winner_d    = 2'b00;
                    serve_dir_d = 1'b1;
                    center_d    = 1'b1;
                end
            end
            StServe: begin
                if (tick) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == ServeFrames) begin
                        state_d = StPlay;
                    end
                end
            end
            StPlay: begin
                if (miss_left && miss_right) begin
                    state_d = StPoint;
                end else if (miss_left) begin
                    if (score2_q < WinScore) score2_d = score2_q + 4'd1;
                    serve_dir_d = 1'b0;
                    state_d     = StPoint;
                end else if (miss_right) begin
                    if (score1_q < WinScore) score1_d = score1_q + 4'd1;
                    serve_dir_d = 1'b1;
                    state_d     = StPoint;
                end
            end
            StPoint: begin
                if (tick) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == PointFrames) begin
                        if (score1_q == WinScore || score2_q == WinScore) begin
                            state_d  = StGameOver;
                            winner_d = (score1_q == WinScore) ? 2'b01 : 2'b10;
                        end else begin
                            state_d  = StServe;
                            center_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) cnt_d = 8'd0;

        // Gating uses the current state, so a tick coinciding with a transition still moves.
        ball_run_d = (state_q == StPlay);
        p1_up_d    = tick & p1_up & ~p1_down & move_en;
        p1_down_d  = tick & p1_down & ~p1_up & move_en;
        p2_up_d    = tick & p2_up_req & ~p2_down_req & move_en;
        p2_down_d  = tick & p2_down_req & ~p2_up_req & move_en;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            score1_q    <= 4'd0;
            score2_q    <= 4'd0;
            winner_q    <= 2'b00;
            serve_dir_q <= 1'b0;
            center_q    <= 1'b0;
            ball_run_q  <= 1'b0;
            start_q     <= 1'b1;
            p1_up_q     <= 1'b0;
            p1_down_q   <= 1'b0;
            p2_up_q     <= 1'b0;
            p2_down_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            winner_q    <= winner_d;
            serve_dir_q <= serve_dir_d;
            center_q    <= center_d;
            ball_run_q  <= ball_run_d;
            start_q     <= start;
            p1_up_q     <= p1_up_d;
            p1_down_q   <= p1_down_d;
            p2_up_q     <= p2_up_d;
            p2_down_q   <= p2_down_d;
        end
    end

    assign p1_up_o       = p1_up_q;
    assign p1_down_o     = p1_down_q;
    assign p2_up_o       = p2_up_q;
    assign p2_down_o     = p2_down_q;
    assign paddle_center = center_q;
    assign ball_run      = ball_run_q;
    assign serve_dir     = serve_dir_q;
    assign score1        = score1_q;
    assign score2        = score2_q;
    assign winner        = winner_q;
    assign state         = state_q;

endmodule

// File: tb/tb_control_juego.sv
// Directed bench for control_juego with WIN_SCORE=3, SERVE_FRAMES=2, POINT_FRAMES=2.
module tb_control_juego;

    logic       clk = 1'b0;
    logic       reset, tick, start;
    logic       p1_up, p1_down, p2_up, p2_down;
    logic       miss_left, miss_right;
    logic [9:0] ball_y, p2_y;
    logic       p1_up_o, p1_down_o, p2_up_o, p2_down_o;
    logic       paddle_center, ball_run, serve_dir;
    logic [3:0] score1, score2;
    logic [1:0] winner;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, POINT = 3'd3, GOVER = 3'd4;

    control_juego #(
        .WIN_SCORE   (3),
        .SERVE_FRAMES(2),
        .POINT_FRAMES(2),
        .AI_DEADBAND (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .start        (start),
        .p1_up        (p1_up),
        .p1_down      (p1_down),
        .p2_up        (p2_up),
        .p2_down      (p2_down),
        .miss_left    (miss_left),
        .miss_right   (miss_right),
        .ball_y       (ball_y),
        .p2_y         (p2_y),
        .p1_up_o      (p1_up_o),
        .p1_down_o    (p1_down_o),
        .p2_up_o      (p2_up_o),
        .p2_down_o    (p2_down_o),
        .paddle_center(paddle_center),
        .ball_run     (ball_run),
        .serve_dir    (serve_dir),
        .score1       (score1),
        .score2       (score2),
        .winner       (winner),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Inputs set before a call are sampled on its edge; outputs are read 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    // From SERVE: two ticks reach PLAY, one more cycle lets ball_run rise.
    task automatic serve_to_play();
        tick_cyc();
        tick_cyc();
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; tick = 1'b0;
        p1_up = 0; p1_down = 0; p2_up = 0; p2_down = 0;
        miss_left = 0; miss_right = 0; ball_y = 10'd0; p2_y = 10'd0;
        cyc(); cyc();
        checks++;
        if (state !== IDLE || score1 !== 4'd0 || score2 !== 4'd0 || winner !== 2'b00) begin
            errors++;
            $display("FAIL reset_regs: state=%0d s1=%0d s2=%0d win=%0d, want 0 0 0 0",
                     state, score1, score2, winner);
        end
        checks++;
        if ({ball_run, serve_dir, paddle_center, p1_up_o, p1_down_o, p2_up_o, p2_down_o}
            !== 7'b0) begin
            errors++;
            $display("FAIL reset_outs: got %b want 0000000",
                     {ball_run, serve_dir, paddle_center, p1_up_o, p1_down_o, p2_up_o,
                      p2_down_o});
        end
    endtask

    task automatic test_start_held();
        reset = 1'b0;
        cyc(); cyc(); cyc();
        checks++;
        if (state !== IDLE) begin
            errors++;
            $display("FAIL start_held: state=%0d want %0d", state, IDLE);
        end
        start = 1'b0; cyc();
        start = 1'b1; cyc();
        checks++;
        if (state !== SERVE || paddle_center !== 1'b1 || serve_dir !== 1'b1) begin
            errors++;
            $display("FAIL start_edge: state=%0d center=%0d dir=%0d want 1 1 1",
                     state, paddle_center, serve_dir);
        end
        cyc();
        checks++;
        if (paddle_center !== 1'b0) begin
            errors++;
            $display("FAIL center_width: center=%0d want 0", paddle_center);
        end
    endtask

    task automatic test_serve();
        p1_up = 1'b1;
        tick_cyc();
        checks++;
        if (p1_up_o !== 1'b1 || state !== SERVE) begin
            errors++;
            $display("FAIL serve_tick1: up=%0d state=%0d want 1 %0d", p1_up_o, state, SERVE);
        end
        cyc();
        checks++;
        if (p1_up_o !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: up=%0d want 0", p1_up_o);
        end
        tick_cyc();
        checks++;
        if (p1_up_o !== 1'b1 || state !== PLAY || ball_run !== 1'b0) begin
            errors++;
            $display("FAIL serve_tick2: up=%0d state=%0d run=%0d want 1 %0d 0",
                     p1_up_o, state, ball_run, PLAY);
        end
        cyc();
        checks++;
        if (ball_run !== 1'b1 || p1_up_o !== 1'b0) begin
            errors++;
            $display("FAIL ball_run_rise: run=%0d up=%0d want 1 0", ball_run, p1_up_o);
        end
        p1_up = 1'b0;
    endtask

    task automatic test_point();
        // Tick with the miss still moves the paddle.
        miss_right = 1'b1; p1_up = 1'b1; tick = 1'b1;
        cyc();
        miss_right = 1'b0; tick = 1'b0;
        checks++;
        if (score1 !== 4'd1 || score2 !== 4'd0 || serve_dir !== 1'b1 || state !== POINT
            || p1_up_o !== 1'b1) begin
            errors++;
            $display("FAIL miss_right: s1=%0d s2=%0d dir=%0d state=%0d up=%0d want 1 0 1 3 1",
                     score1, score2, serve_dir, state, p1_up_o);
        end
        cyc();
        checks++;
        if (ball_run !== 1'b0) begin
            errors++;
            $display("FAIL ball_run_fall: run=%0d want 0", ball_run);
        end
        tick_cyc();
        checks++;
        if (p1_up_o !== 1'b0 || state !== POINT) begin
            errors++;
            $display("FAIL point_frozen: up=%0d state=%0d want 0 %0d", p1_up_o, state, POINT);
        end
        tick_cyc();
        checks++;
        if (state !== SERVE || paddle_center !== 1'b1 || p1_up_o !== 1'b0) begin
            errors++;
            $display("FAIL point_to_serve: state=%0d center=%0d up=%0d want 1 1 0",
                     state, paddle_center, p1_up_o);
        end
        p1_up = 1'b0;
        serve_to_play();
    endtask

    task automatic test_double_miss();
        miss_left = 1'b1; miss_right = 1'b1;
        cyc();
        miss_left = 1'b0; miss_right = 1'b0;
        checks++;
        if (score1 !== 4'd1 || score2 !== 4'd0 || serve_dir !== 1'b1 || state !== POINT) begin
            errors++;
            $display("FAIL double_miss: s1=%0d s2=%0d dir=%0d state=%0d want 1 0 1 3",
                     score1, score2, serve_dir, state);
        end
        tick_cyc(); tick_cyc();
        p1_up = 1'b1; p1_down = 1'b1;
        tick_cyc();
        checks++;
        if (p1_up_o !== 1'b0 || p1_down_o !== 1'b0) begin
            errors++;
            $display("FAIL both_buttons: up=%0d down=%0d want 0 0", p1_up_o, p1_down_o);
        end
        p1_up = 1'b0;
`ifndef CONTROL_JUEGO_AI_P2_EN
        p2_down = 1'b1;
`endif
        tick_cyc();
        checks++;
        if (p1_down_o !== 1'b1 || p1_up_o !== 1'b0 || state !== PLAY) begin
            errors++;
            $display("FAIL p1_down: down=%0d up=%0d state=%0d want 1 0 2",
                     p1_down_o, p1_up_o, state);
        end
`ifndef CONTROL_JUEGO_AI_P2_EN
        checks++;
        if (p2_down_o !== 1'b1 || p2_up_o !== 1'b0) begin
            errors++;
            $display("FAIL p2_down: down=%0d up=%0d want 1 0", p2_down_o, p2_up_o);
        end
`endif
        p1_down = 1'b0; p2_down = 1'b0;
        cyc();
    endtask

    task automatic test_game_over();
        for (int i = 1; i <= 3; i++) begin
            miss_left = 1'b1;
            cyc();
            miss_left = 1'b0;
            checks++;
            if (score2 !== 4'(i) || serve_dir !== 1'b0 || state !== POINT) begin
                errors++;
                $display("FAIL p2_point%0d: s2=%0d dir=%0d state=%0d want %0d 0 3",
                         i, score2, serve_dir, state, i);
            end
            tick_cyc(); tick_cyc();
            if (i < 3) serve_to_play();
        end
        checks++;
        if (state !== GOVER || winner !== 2'b10 || score1 !== 4'd1 || score2 !== 4'd3) begin
            errors++;
            $display("FAIL game_over: state=%0d win=%0d s1=%0d s2=%0d want 4 2 1 3",
                     state, winner, score1, score2);
        end
        miss_left = 1'b1;
        cyc();
        miss_left = 1'b0;
        checks++;
        if (score2 !== 4'd3 || state !== GOVER) begin
            errors++;
            $display("FAIL miss_ignored: s2=%0d state=%0d want 3 4", score2, state);
        end
        start = 1'b0; cyc();
        start = 1'b1; cyc();
        checks++;
        if (state !== SERVE || score1 !== 4'd0 || score2 !== 4'd0 || winner !== 2'b00
            || paddle_center !== 1'b1 || serve_dir !== 1'b1) begin
            errors++;
            $display("FAIL restart: state=%0d s1=%0d s2=%0d win=%0d ctr=%0d dir=%0d want 1 0 0 0 1 1",
                     state, score1, score2, winner, paddle_center, serve_dir);
        end
    endtask

`ifdef CONTROL_JUEGO_AI_P2_EN
    task automatic test_ai();
        serve_to_play();
        ball_y = 10'd200; p2_y = 10'd180;
        tick_cyc();
        checks++;
        if (p2_up_o !== 1'b1 || p2_down_o !== 1'b0) begin
            errors++;
            $display("FAIL ai_up: up=%0d down=%0d want 1 0", p2_up_o, p2_down_o);
        end
        ball_y = 10'd182;
        tick_cyc();
        checks++;
        if (p2_up_o !== 1'b0 || p2_down_o !== 1'b0) begin
            errors++;
            $display("FAIL ai_deadband: up=%0d down=%0d want 0 0", p2_up_o, p2_down_o);
        end
        ball_y = 10'd100; p2_up = 1'b1;
        tick_cyc();
        p2_up = 1'b0;
        checks++;
        if (p2_up_o !== 1'b0 || p2_down_o !== 1'b1) begin
            errors++;
            $display("FAIL ai_down: up=%0d down=%0d want 0 1", p2_up_o, p2_down_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_start_held();
        test_serve();
        test_point();
        test_double_miss();
        test_game_over();
`ifdef CONTROL_JUEGO_AI_P2_EN
        test_ai();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_juego.md
Name: control_juego

Overview:
Game sequencer for the pong datapath. Runs the match state machine (idle, serve, play, point, game over) and keeps both scores. Gates player up/down commands into one-cycle, frame-tick-aligned movement pulses for the two paddle instances, and starts and stops the ball logic. Sits between the button/frame-tick logic and the paddle/ball blocks.

Parameters:
WIN_SCORE, 9, points needed to win; legal range 1..15.
SERVE_FRAMES, 60, frame ticks spent in SERVE before the ball is released; legal range 1..255.
POINT_FRAMES, 90, frame ticks spent in POINT after a miss; legal range 1..255.
AI_DEADBAND, 4, pixel deadband for automatic player 2; used only with the optional feature.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick  in  1  one-cycle frame-rate pulse
start  in  1  start button level, already debounced
p1_up, p1_down  in  1 each  player 1 button levels
p2_up, p2_down  in  1 each  player 2 button levels
miss_left  in  1  one-cycle pulse: ball passed player 1
miss_right  in  1  one-cycle pulse: ball passed player 2
ball_y  in  10  ball vertical position
p2_y  in  10  paddle 2 position
p1_up_o, p1_down_o, p2_up_o, p2_down_o  out  1 each  registered paddle movement pulses
paddle_center  out  1  one-cycle pulse that recenters both paddles
ball_run  out  1  ball enabled while high
serve_dir  out  1  serve direction: 0 = toward player 1, 1 = toward player 2
score1, score2  out  4 each  scores
winner  out  2  00 = none, 01 = player 1, 10 = player 2
state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4

Behaviour:
- Reset. Synchronous; takes priority over all other inputs, including mid-serve or mid-point. After reset:
  - state = IDLE; scores = 0; winner = 00; serve_dir = 0; frame counter = 0.
  - All pulse outputs = 0; ball_run = 0.
  - Start edge register is loaded with 1, so a start button held through reset does not trigger a start.
- Start edge. start_edge = start & ~start_q, where start_q is start registered by one clk.
- IDLE: on start_edge →
  - next state SERVE;
  - scores cleared, winner = 00, serve_dir = 1;
  - paddle_center pulses high for exactly one cycle.
- SERVE:
  - frame counter counts ticks;
  - on the tick that brings the count to SERVE_FRAMES → next state PLAY, counter cleared;
  - ball_run goes high the cycle after entry to PLAY.
- PLAY: ball_run = 1.
  - miss_left alone → score2 +1, serve_dir = 0, next state POINT.
  - miss_right alone → score1 +1, serve_dir = 1, next state POINT.
  - Both in the same cycle → no score change, serve_dir unchanged, next state POINT.
  - ball_run drops the cycle after leaving PLAY.
  - Misses in any state other than PLAY are ignored.
- POINT:
  - paddles frozen; counts POINT_FRAMES ticks;
  - then, if score1 or score2 == WIN_SCORE → next state GAMEOVER, winner set;
  - otherwise → next state SERVE with a paddle_center pulse.
- GAMEOVER:
  - scores and winner held;
  - start_edge behaves exactly as in IDLE (new match).
- Scores. 4-bit, saturate at WIN_SCORE, never wrap.
- Frame counter. 8-bit; cleared on every state change.
- Movement pulses:
  - pN_up_o <= tick & pN_up & ~pN_down & move_en; down is symmetric.
  - move_en = 1 while the current state is SERVE or PLAY.
  - Both buttons pressed → no pulse.
  - Latency is 1 clk after tick; each pulse is exactly 1 clk wide.
- Simultaneous events:
  - A tick in the same cycle as a miss still produces movement pulses, since decoding uses the current state.
  - A tick on the final SERVE count also produces movement pulses.
- All outputs are registered.

Optional Feature:
Macro: CONTROL_JUEGO_AI_P2_EN.
- Defined: p2_up and p2_down are ignored. Player 2 is automatic and follows the same tick gating and move_en rules:
  - p2_up_o asserted when ball_y > p2_y + AI_DEADBAND;
  - p2_down_o asserted when ball_y + AI_DEADBAND < p2_y;
  - comparisons done in 11 bits so they cannot overflow;
  - neither pulse asserted inside the deadband.
- Not defined: player 2 is driven by the buttons; ball_y and p2_y are unused.

Test Plan:
All scenarios use WIN_SCORE=3, SERVE_FRAMES=2, POINT_FRAMES=2.
1. Start held high through reset, then released and pressed again → no transition while held; on the re-press, state IDLE→SERVE, one paddle_center pulse, serve_dir=1.
2. In SERVE, 2 ticks with p1_up=1 → two p1_up_o pulses, each 1 clk after its tick; state=PLAY after the 2nd tick; ball_run=1 the next cycle.
3. In PLAY, single miss_right pulse → score1=1, serve_dir=1, state=POINT, ball_run=0. After 2 ticks → SERVE with a paddle_center pulse. During POINT, ticks with p1_up=1 → no pulses.
4. In PLAY, miss_left and miss_right in the same cycle → scores unchanged, state=POINT. Separately, p1_up=p1_down=1 with a tick → no movement pulse.
5. Player 2 scores 3 times → score2=3, and after POINT completes state=GAMEOVER, winner=10. Then start_edge → scores=0, winner=00, state=SERVE.
6. With CONTROL_JUEGO_AI_P2_EN defined, in PLAY:
   - ball_y=200, p2_y=180, tick → p2_up_o pulse;
   - ball_y=182, p2_y=180 → no pulse;
   - ball_y=100, p2_y=180 → p2_down_o pulse.
